serial_adder_sub: RTL and testbench
===================================

# serial_adder_sub

Bit-serial, parametrised add/subtract unit: the multi-bit successor to our single-bit full adder cell. One registered full-adder slice plus a carry flip-flop processes a WIDTH-bit operand pair LSB-first over WIDTH cycles. It trades latency for area and exposes a start/busy/done handshake so it can sit behind a sequencer or a test driver. It also provides carry-in, subtract mode and signed overflow, none of which the combinational cell has.

## Interface

- WIDTH, 8, operand and result width in bits; legal range 2..64

- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset, sampled on rising clk
- start  in  1  request; sampled only in IDLE or DONE
- a  in  WIDTH  operand A, captured on the accepting edge
- b  in  WIDTH  operand B, captured on the accepting edge
- cin  in  1  carry-in, captured on the accepting edge
- sub  in  1  mode, captured on the accepting edge; 0 = A+B+cin, 1 = A-B-cin (A + ~B + ~cin)
- busy  out  1  high while bits are being processed
- done  out  1  single-cycle completion pulse
- sum  out  WIDTH  result, registered
- carry  out  1  carry out of the MSB; in subtract mode 1 = no borrow
- overflow  out  1  signed overflow: carry into MSB XOR carry out of MSB

## Operation

- States:
  - IDLE: waiting for start.
  - RUN: processing bits.
  - DONE: one cycle, done high.
- IDLE/DONE with start=1:
  - Latch a into shift register SA.
  - Latch b ^ {WIDTH{sub}} into SB.
  - Set carry flop C = cin ^ sub.
  - Clear bit counter to 0.
  - Go to RUN.
- IDLE with start=0: stay in IDLE. DONE with start=0: go to IDLE.
- RUN, each cycle:
  - s = SA[0]^SB[0]^C; C <= majority(SA[0],SB[0],C).
  - s shifts into result shift register SR at the MSB end. SA and SB shift right.
  - Counter increments.
  - When counter = WIDTH-1, go to DONE on that edge.
- Overflow capture: on the edge that processes bit WIDTH-1, record the carry into bit WIDTH-1 (the value of C before that edge).
- Output update: sum, carry and overflow change only on the RUN→DONE edge. They are loaded from SR (including the final bit), the final C, and the recorded carry-in-to-MSB XOR final C. They hold that value until the next completion or reset.
- start while in RUN: ignored. No queueing, no restart.
- Operands, cin and sub are don't-care except on the accepting edge.
- Arithmetic is modulo 2^WIDTH. Subtract with cin=0 gives A-B.

## Timing

- Reset (rst_n=0 at a rising edge), from any state including mid-RUN:
  - State = IDLE.
  - busy = 0, done = 0.
  - sum = 0, carry = 0, overflow = 0.
  - Internal SA/SB/SR/C/counter cleared.
  - An in-flight operation is discarded, and no done is produced for it.
- Accepting edge E0: busy = 1 from E0 through the edge E0+WIDTH.
- At edge E0+WIDTH:
  - Bit WIDTH-1 is processed.
  - busy → 0, done → 1, and sum/carry/overflow are valid.
- done falls at edge E0+WIDTH+1.
- Latency: start-to-done = WIDTH cycles.
- Back-to-back: start=1 during the DONE cycle is accepted at E0+WIDTH+1. busy rises on the same edge that done falls, so one op completes every WIDTH+1 cycles.
- busy and done are never high together. done is never high for more than one cycle.
- Outputs are purely registered; there is no combinational path from inputs to outputs.

## Test plan

- Add carry-out, WIDTH=8: a=8'hFF, b=8'h01, cin=0, sub=0 → after 8 cycles done=1, sum=8'h00, carry=1, overflow=0.
- Signed overflow: a=8'h7F, b=8'h01, cin=0, sub=0 → sum=8'h80, carry=0, overflow=1. Repeat with cin=1, b=8'h00 → same result.
- Subtract: a=8'h05, b=8'h07, sub=1, cin=0 → sum=8'hFE, carry=0 (borrow), overflow=0. Second case: a=8'h80, b=8'h01, sub=1 → sum=8'h7F, carry=1, overflow=1.
- Handshake:
  - start pulsed at cycles 3 and 6 of a RUN → ignored; single done at E0+8 with the first op's result.
  - start held high through DONE → second op accepted; done pulses exactly every 9 cycles.
- Reset mid-op: rst_n=0 at RUN cycle 4 → next edge busy=0, sum=0, carry=0, overflow=0. No done pulse follows; a fresh op after release completes normally.
- Random: WIDTH=8 and WIDTH=32, 1000 random {a,b,cin,sub} ops. Compare {carry,sum} against a+b+cin (or a+~b+~cin), and overflow against a sign-bit check. Zero mismatches; busy/done protocol assertions hold throughout.

Source files
------------

// File: rtl/serial_adder_sub_if.sv
// Handshake and operand/result bundle for the bit-serial add/subtract unit.
// The requester drives start and the operands; the unit returns status and result.
interface serial_adder_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             overflow;

    modport master (
        output start, a, b, cin, sub,
        input  busy, done, sum, carry, overflow
    );

    modport slave (
        input  start, a, b, cin, sub,
        output busy, done, sum, carry, overflow
    );
endinterface

// File: rtl/serial_adder_sub.sv
// Bit-serial add/subtract unit: one full-adder slice plus a carry flop walks a
// WIDTH-bit operand pair LSB-first. A result appears WIDTH cycles after start
// is accepted. Subtraction is A + ~B + ~cin, so carry=1 means "no borrow".
module serial_adder_sub #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_adder_sub_if.slave  bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic             accept_s;
    logic             last_s;
    logic             bit_s;
    logic             cout_s;

    logic [WIDTH-1:0] sa_r;
    logic [WIDTH-1:0] sb_r;
    logic [WIDTH-1:0] sr_r;
    logic             c_r;
    logic [CW-1:0]    cnt_r;

    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] sum_r;
    logic             carry_r;
    logic             overflow_r;

    // Carry out of a full-adder slice.
    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    assign bit_s  = sa_r[0] ^ sb_r[0] ^ c_r;
    assign cout_s = maj3(sa_r[0], sb_r[0], c_r);
    assign last_s = (cnt_r == LAST_CNT);

    // Next-state decode; start is only honoured in IDLE or DONE.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nxt_s = ST_RUN;
                    accept_s    = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (bus.start) begin
                    state_nxt_s = ST_RUN;
                    accept_s    = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                accept_s    = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand capture, serial datapath and registered result/status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sa_r       <= '0;
            sb_r       <= '0;
            sr_r       <= '0;
            c_r        <= 1'b0;
            cnt_r      <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            sum_r      <= '0;
            carry_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s == ST_RUN);
            done_r <= (state_nxt_s == ST_DONE);
            if (accept_s) begin
                sa_r  <= bus.a;
                sb_r  <= bus.b ^ {WIDTH{bus.sub}};
                c_r   <= bus.cin ^ bus.sub;
                cnt_r <= '0;
            end else if (state_r == ST_RUN) begin
                sa_r  <= {1'b0, sa_r[WIDTH-1:1]};
                sb_r  <= {1'b0, sb_r[WIDTH-1:1]};
                sr_r  <= {bit_s, sr_r[WIDTH-1:1]};
                c_r   <= cout_s;
                cnt_r <= cnt_r + CW'(1);
                // c_r here is the carry into the MSB; compare it with the carry out.
                if (last_s) begin
                    sum_r      <= {bit_s, sr_r[WIDTH-1:1]};
                    carry_r    <= cout_s;
                    overflow_r <= c_r ^ cout_s;
                end else begin
                    sum_r      <= sum_r;
                    carry_r    <= carry_r;
                    overflow_r <= overflow_r;
                end
            end else begin
                sa_r  <= sa_r;
                sb_r  <= sb_r;
                c_r   <= c_r;
                cnt_r <= cnt_r;
            end
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.sum      = sum_r;
    assign bus.carry    = carry_r;
    assign bus.overflow = overflow_r;
endmodule

// File: tb/tb_serial_adder_sub.sv
// Bench for serial_adder_sub: directed table at WIDTH=8, handshake and reset
// corner sequences, and random ops at WIDTH=8 and WIDTH=32 against an
// arithmetic reference model.
module tb_serial_adder_sub;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    serial_adder_sub_if #(.WIDTH(8))  bus8 ();
    serial_adder_sub_if #(.WIDTH(32)) bus32 ();

    serial_adder_sub #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
    serial_adder_sub #(.WIDTH(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

    int   total = 0;
    int   bad   = 0;
    logic prev_done8  = 1'b0;
    logic prev_done32 = 1'b0;

    typedef struct packed {
        logic [63:0] sum;
        logic        carry;
        logic        ovf;
    } res_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] sum;
        logic       carry;
        logic       ovf;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain wide arithmetic plus a sign-bit overflow rule.
    function automatic res_t ref_model(input int w, input logic [63:0] a, input logic [63:0] b,
                                       input logic cin, input logic sub);
        res_t        r;
        logic [63:0] mask;
        logic [63:0] am;
        logic [63:0] bm;
        logic [64:0] full;
        mask    = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        am      = a & mask;
        bm      = (sub ? ~b : b) & mask;
        full    = {1'b0, am} + {1'b0, bm} + {64'd0, cin ^ sub};
        r.sum   = full[63:0] & mask;
        r.carry = full[w];
        r.ovf   = (am[w-1] == bm[w-1]) && (r.sum[w-1] != am[w-1]);
        return r;
    endfunction

    function automatic res_t read_out(input int w);
        res_t r;
        if (w == 8) begin
            r.sum = {56'd0, bus8.sum}; r.carry = bus8.carry; r.ovf = bus8.overflow;
        end else begin
            r.sum = {32'd0, bus32.sum}; r.carry = bus32.carry; r.ovf = bus32.overflow;
        end
        return r;
    endfunction

    function automatic logic get_busy(input int w);
        return (w == 8) ? bus8.busy : bus32.busy;
    endfunction

    function automatic logic get_done(input int w);
        return (w == 8) ? bus8.done : bus32.done;
    endfunction

    task automatic drive(input int w, input logic st, input logic [63:0] a, input logic [63:0] b,
                         input logic cin, input logic sub);
        if (w == 8) begin
            bus8.start = st; bus8.a = a[7:0]; bus8.b = b[7:0]; bus8.cin = cin; bus8.sub = sub;
        end else begin
            bus32.start = st; bus32.a = a[31:0]; bus32.b = b[31:0]; bus32.cin = cin; bus32.sub = sub;
        end
    endtask

    // Advance one clock, sample after the edge and check the busy/done protocol.
    task automatic tick();
        @(posedge clk);
        #1;
        chk("busy_done_excl8",  {63'd0, bus8.busy & bus8.done}, 64'd0);
        chk("busy_done_excl32", {63'd0, bus32.busy & bus32.done}, 64'd0);
        chk("done_single8",     {63'd0, prev_done8 & bus8.done}, 64'd0);
        chk("done_single32",    {63'd0, prev_done32 & bus32.done}, 64'd0);
        prev_done8  = bus8.done;
        prev_done32 = bus32.done;
    endtask

    // One operation: accept, then wait (bounded) for done.
    task automatic run_op(input int w, input logic [63:0] a, input logic [63:0] b,
                          input logic cin, input logic sub, output res_t got, output int lat);
        drive(w, 1'b1, a, b, cin, sub);
        tick();
        drive(w, 1'b0, a, b, cin, sub);
        chk("busy_after_accept", {63'd0, get_busy(w)}, 64'd1);
        lat = -1;
        for (int k = 1; k <= w + 4; k++) begin
            tick();
            if (get_done(w)) begin
                lat = k;
                break;
            end
        end
        got = read_out(w);
    endtask

    task automatic op_and_check(input int w, input logic [63:0] a, input logic [63:0] b,
                                input logic cin, input logic sub);
        res_t got;
        res_t exp;
        int   lat;
        run_op(w, a, b, cin, sub, got, lat);
        exp = ref_model(w, a, b, cin, sub);
        chk("latency", 64'(lat), 64'(w));
        if (got !== exp) begin
            $display("FAIL rand_w%0d a=%h b=%h cin=%b sub=%b: got %h/%b/%b expected %h/%b/%b",
                     w, a, b, cin, sub, got.sum, got.carry, got.ovf, exp.sum, exp.carry, exp.ovf);
            bad++;
        end
        total++;
    endtask

    initial begin
        vec_t tbl[7];
        res_t got;
        int   lat;
        int   ndone;
        int   first;
        logic [7:0] s8;

        tbl[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[2] = '{8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[3] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
        tbl[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        tbl[5] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
        tbl[6] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};

        rst_n = 1'b0;
        drive(8, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
        drive(32, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
        repeat (3) tick();
        chk("rst_busy",  {63'd0, bus8.busy}, 64'd0);
        chk("rst_done",  {63'd0, bus8.done}, 64'd0);
        chk("rst_sum",   {56'd0, bus8.sum}, 64'd0);
        chk("rst_carry", {63'd0, bus8.carry}, 64'd0);
        chk("rst_ovf",   {63'd0, bus8.overflow}, 64'd0);
        chk("rst_sum32", {32'd0, bus32.sum}, 64'd0);
        rst_n = 1'b1;
        tick();

        // Directed table at WIDTH=8.
        for (int i = 0; i < 7; i++) begin
            run_op(8, {56'd0, tbl[i].a}, {56'd0, tbl[i].b}, tbl[i].cin, tbl[i].sub, got, lat);
            chk($sformatf("tbl%0d_lat", i),   64'(lat), 64'd8);
            chk($sformatf("tbl%0d_sum", i),   got.sum, {56'd0, tbl[i].sum});
            chk($sformatf("tbl%0d_carry", i), {63'd0, got.carry}, {63'd0, tbl[i].carry});
            chk($sformatf("tbl%0d_ovf", i),   {63'd0, got.ovf}, {63'd0, tbl[i].ovf});
            tick();
        end

        // start pulses during RUN are ignored.
        drive(8, 1'b1, 64'h12, 64'h34, 1'b0, 1'b0);
        tick();
        ndone = 0;
        first = -1;
        s8 = 8'd0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 3 || k == 6) drive(8, 1'b1, 64'hFF, 64'hFF, 1'b0, 1'b1);
            else bus8.start = 1'b0;
            tick();
            if (bus8.done) begin
                ndone++;
                if (first < 0) begin
                    first = k;
                    s8 = bus8.sum;
                end
            end
        end
        bus8.start = 1'b0;
        chk("ign_ndone", 64'(ndone), 64'd1);
        chk("ign_lat",   64'(first), 64'd8);
        chk("ign_sum",   {56'd0, s8}, 64'h46);

        // start held through DONE: back-to-back acceptance, done every 9 cycles.
        drive(8, 1'b1, 64'h10, 64'h20, 1'b0, 1'b0);
        tick();
        first = -1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (bus8.done) begin
                first = k;
                break;
            end
        end
        chk("b2b_lat1", 64'(first), 64'd8);
        chk("b2b_sum1", {56'd0, bus8.sum}, 64'h30);
        drive(8, 1'b1, 64'hC0, 64'hA0, 1'b0, 1'b0);
        tick();
        chk("b2b_busy", {63'd0, bus8.busy}, 64'd1);
        chk("b2b_done", {63'd0, bus8.done}, 64'd0);
        first = -1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (bus8.done) begin
                first = k + 1;
                break;
            end
        end
        chk("b2b_interval", 64'(first), 64'd9);
        chk("b2b_sum2",   {56'd0, bus8.sum}, 64'h60);
        chk("b2b_carry2", {63'd0, bus8.carry}, 64'd1);
        chk("b2b_ovf2",   {63'd0, bus8.overflow}, 64'd1);
        bus8.start = 1'b0;
        tick();
        chk("b2b_idle_busy", {63'd0, bus8.busy}, 64'd0);
        chk("b2b_idle_done", {63'd0, bus8.done}, 64'd0);

        // Reset in the middle of an operation discards it.
        drive(8, 1'b1, 64'h33, 64'h44, 1'b0, 1'b0);
        tick();
        bus8.start = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        chk("mid_rst_busy",  {63'd0, bus8.busy}, 64'd0);
        chk("mid_rst_done",  {63'd0, bus8.done}, 64'd0);
        chk("mid_rst_sum",   {56'd0, bus8.sum}, 64'd0);
        chk("mid_rst_carry", {63'd0, bus8.carry}, 64'd0);
        chk("mid_rst_ovf",   {63'd0, bus8.overflow}, 64'd0);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (bus8.done) ndone++;
        end
        chk("mid_rst_no_done", 64'(ndone), 64'd0);
        op_and_check(8, 64'h0F, 64'h01, 1'b1, 1'b1);
        tick();

        // Random operations at both widths.
        for (int i = 0; i < 1000; i++) begin
            op_and_check(8, {56'd0, 8'($urandom)}, {56'd0, 8'($urandom)},
                         1'($urandom), 1'($urandom));
        end
        tick();
        for (int i = 0; i < 1000; i++) begin
            op_and_check(32, {32'd0, $urandom}, {32'd0, $urandom},
                         1'($urandom), 1'($urandom));
        end
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
